// File: rtl/uart_rx_toggle_if.sv
// Receiver-side bundle: serial line in, byte bus plus level toggle out toward the slow domain.
// The receiver uses the master modport; the line driver/consumer uses slave.
interface uart_rx_toggle_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx_in;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_toggle;
   logic                 frame_err;
   logic                 rx_busy;

   modport master (
      input  rx_in,
      output rx_data,
      output rx_toggle,
      output frame_err,
      output rx_busy
   );

   modport slave (
      output rx_in,
      input  rx_data,
      input  rx_toggle,
      input  frame_err,
      input  rx_busy
   );
endinterface

// File: rtl/uart_rx_toggle.sv
// 8N1 UART receiver: holds each good byte on rx_data and flips rx_toggle once per byte,
// so a downstream toggle synchronizer can turn it into a single write pulse in the slow domain.
module uart_rx_toggle #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
) (
   input logic             clk,
   input logic             rst,
   uart_rx_toggle_if.master bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   logic                 sync_1;
   logic                 rx_s;

   state_t               state,      state_next;
   logic [CNT_W-1:0]     cnt,        cnt_next;
   logic [BIT_W-1:0]     bit_idx,    bit_next;
   logic [DATA_BITS-1:0] shift_reg,  shift_next;
   logic [DATA_BITS-1:0] data_reg,   data_next;
   logic                 toggle_reg, toggle_next;
   logic                 ferr_reg,   ferr_next;

   // Two-flop synchronizer; resets to the idle-high line level so reset never fakes a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= bus.rx_in;
         rx_s   <= sync_1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         data_reg   <= '0;
         toggle_reg <= 1'b0;
         ferr_reg   <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         bit_idx    <= bit_next;
         shift_reg  <= shift_next;
         data_reg   <= data_next;
         toggle_reg <= toggle_next;
         ferr_reg   <= ferr_next;
      end
   end

   // rx_data and rx_toggle only move together on a good stop bit, which keeps the bus
   // stable for a whole frame after every flip as the slow domain expects.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      bit_next    = bit_idx;
      shift_next  = shift_reg;
      data_next   = data_reg;
      toggle_next = toggle_reg;
      ferr_next   = 1'b0;

      case (state)
         IDLE: begin
            cnt_next = '0;
            if (!rx_s) begin
               state_next = START;
            end
         end

         START: begin
            if (cnt == HALF_LAST) begin
               if (!rx_s) begin
                  state_next = DATA;
                  cnt_next   = '0;
                  bit_next   = '0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt == FULL_LAST) begin
               shift_next[bit_idx] = rx_s;
               cnt_next            = '0;
               if (bit_idx == LAST_BIT) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_idx + BIT_W'(1);
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         // Leaving at mid-stop-bit leaves half a bit of margin to catch a back-to-back start edge.
         STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_next = '0;
               if (rx_s) begin
                  data_next   = shift_reg;
                  toggle_next = ~toggle_reg;
                  state_next  = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = BREAK;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         BREAK: begin
            cnt_next = '0;
            if (rx_s) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign bus.rx_data   = data_reg;
   assign bus.rx_toggle = toggle_reg;
   assign bus.frame_err = ferr_reg;
   assign bus.rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_toggle.sv
// Directed bench for uart_rx_toggle at 16 clocks per bit: table of good frames, then
// glitch, break/frame-error and mid-frame reset sequences.
module tb_uart_rx_toggle;

   localparam int CPB = 16;
   localparam int DB  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_toggle_if #(.DATA_BITS(DB)) bus ();

   uart_rx_toggle #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         gap;
      logic       exp_toggle;
      logic [7:0] exp_data;
   } frame_vec_t;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;
   int start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Flip/pulse bookkeeping, ignoring the cycles where reset is rewriting the outputs.
   logic       rst_q = 1'b1;
   int         flips = 0;
   int         ferr_pulses = 0;
   int         ferr_run = 0;
   int         ferr_max = 0;
   int         data_glitches = 0;
   int         last_flip_cyc = 0;
   logic       prev_toggle = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) rst_q <= rst;

   always @(negedge clk) begin
      if (!rst_q) begin
         if (bus.rx_toggle !== prev_toggle) begin
            flips++;
            last_flip_cyc = cyc;
         end else if (bus.rx_data !== prev_data) begin
            data_glitches++;
         end
         if (bus.frame_err === 1'b1) begin
            ferr_run++;
            if (ferr_run == 1) ferr_pulses++;
            if (ferr_run > ferr_max) ferr_max = ferr_run;
         end else begin
            ferr_run = 0;
         end
      end
      prev_toggle = bus.rx_toggle;
      prev_data   = bus.rx_data;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual >= lo && actual <= hi) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic driveBit(input logic b);
      bus.rx_in = b;
      waitCycles(CPB);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
      start_cyc = cyc;
      driveBit(1'b0);
      for (int i = 0; i < DB; i++) driveBit(data[i]);
      driveBit(stop_bit);
   endtask

   frame_vec_t vecs[3];
   int f0, e0, flip1, busy_cycles;
   logic [7:0] partial;

   initial begin
      vecs[0] = '{data: 8'hA5, gap: 20, exp_toggle: 1'b1, exp_data: 8'hA5};
      vecs[1] = '{data: 8'h3C, gap: 0,  exp_toggle: 1'b0, exp_data: 8'h3C};
      vecs[2] = '{data: 8'hC3, gap: 20, exp_toggle: 1'b1, exp_data: 8'hC3};

      bus.rx_in = 1'b1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      waitCycles(50);

      checkOutput("reset_data",   int'(bus.rx_data),   0);
      checkOutput("reset_toggle", int'(bus.rx_toggle), 0);
      checkOutput("reset_ferr",   int'(bus.frame_err), 0);
      checkOutput("reset_busy",   int'(bus.rx_busy),   0);
      checkOutput("idle_flips",   flips,               0);

      // Good frames; entry 1 runs straight into entry 2 with no idle gap.
      for (int i = 0; i < 3; i++) begin
         f0 = flips;
         e0 = ferr_pulses;
         applyStimulus(vecs[i].data, 1'b1);
         checkOutput($sformatf("v%0d_flips", i),   flips - f0, 1);
         checkRange ($sformatf("v%0d_latency", i), last_flip_cyc - start_cyc, 152, 156);
         checkOutput($sformatf("v%0d_data", i),    int'(bus.rx_data),   int'(vecs[i].exp_data));
         checkOutput($sformatf("v%0d_toggle", i),  int'(bus.rx_toggle), int'(vecs[i].exp_toggle));
         checkOutput($sformatf("v%0d_ferr", i),    ferr_pulses - e0, 0);
         if (i == 1) flip1 = last_flip_cyc;
         if (i == 2) checkRange("b2b_spacing", last_flip_cyc - flip1, 159, 161);
         waitCycles(vecs[i].gap);
      end

      // Four-cycle low glitch must be rejected at the mid-start-bit sample.
      f0 = flips;
      busy_cycles = 0;
      bus.rx_in = 1'b0;
      for (int i = 0; i < 34; i++) begin
         @(posedge clk);
         #1;
         busy_cycles += int'(bus.rx_busy);
         if (i == 3) bus.rx_in = 1'b1;
      end
      checkRange ("glitch_busy",   busy_cycles, 1, 8);
      checkOutput("glitch_flips",  flips - f0, 0);
      checkOutput("glitch_data",   int'(bus.rx_data), 8'hC3);

      // Stop bit low, then line held low three more bit times.
      f0 = flips;
      e0 = ferr_pulses;
      applyStimulus(8'h55, 1'b0);
      waitCycles(3 * CPB);
      checkOutput("break_ferr",   ferr_pulses - e0, 1);
      checkOutput("break_width",  ferr_max, 1);
      checkOutput("break_flips",  flips - f0, 0);
      checkOutput("break_data",   int'(bus.rx_data), 8'hC3);
      checkOutput("break_busy",   int'(bus.rx_busy), 1);
      bus.rx_in = 1'b1;
      waitCycles(20);
      checkOutput("break_exit_busy", int'(bus.rx_busy), 0);
      applyStimulus(8'h81, 1'b1);
      waitCycles(20);
      checkOutput("after_break_flips",  flips - f0, 1);
      checkOutput("after_break_data",   int'(bus.rx_data),   8'h81);
      checkOutput("after_break_toggle", int'(bus.rx_toggle), 0);
      checkOutput("after_break_ferr",   ferr_pulses - e0, 1);

      // Reset pulse in the middle of data bit 4 abandons the frame.
      f0 = flips;
      e0 = ferr_pulses;
      partial = 8'h5A;
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(partial[i]);
      bus.rx_in = partial[4];
      waitCycles(8);
      checkOutput("pre_rst_busy", int'(bus.rx_busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.rx_in = 1'b1;
      checkOutput("rst_busy",   int'(bus.rx_busy),   0);
      checkOutput("rst_toggle", int'(bus.rx_toggle), 0);
      checkOutput("rst_data",   int'(bus.rx_data),   0);
      waitCycles(40);
      checkOutput("rst_flips",  flips - f0, 0);
      checkOutput("rst_ferr",   ferr_pulses - e0, 0);
      applyStimulus(8'h0F, 1'b1);
      waitCycles(20);
      checkOutput("post_rst_flips",  flips - f0, 1);
      checkOutput("post_rst_data",   int'(bus.rx_data),   8'h0F);
      checkOutput("post_rst_toggle", int'(bus.rx_toggle), 1);
      checkOutput("post_rst_ferr",   ferr_pulses - e0, 0);

      checkOutput("data_stable", data_glitches, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
